// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared constants, fetch FSM encodings and helpers for the IF stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam logic [31:0] c_rv_nop = 32'h0000_0013;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_req     = 2'd1;
    localparam logic [1:0] c_st_discard = 2'd2;
    localparam logic [1:0] c_st_hold    = 2'd3;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_reg.sv
// ============================================================================
// Module      : fetch_skid_reg
// Description : One-entry instruction holding register used while ID is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_clear,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_full
);

    logic [31:0] r_data;
    logic        r_full;

    // Clear beats load so a redirect can never resurrect a dropped instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= c_rv_nop;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : IF stage with IF/ID register, single outstanding imem request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             IFIDWrite,
    input  logic             IFIDFlush,
    input  logic             PCSrc,
    input  logic [31:0]      BranchTarget,
    output logic             IMemReq,
    output logic [31:0]      IMemAddr,
    input  logic [31:0]      IMemRdata,
    input  logic             IMemValid,
    output logic [31:0]      IFIDInstr,
    output logic [31:0]      IFIDPC,
    output logic             IFIDValid,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_disc_addr;
    logic [31:0]      r_ifid_instr;
    logic [31:0]      r_ifid_pc;
    logic             r_ifid_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic        w_in_req;
    logic        w_in_disc;
    logic        w_in_hold;
    logic        w_fetch_hit;
    logic        w_take_fetch;
    logic        w_to_skid;
    logic        w_take_skid;
    logic        w_deliver;
    logic        w_advance;
    logic        w_skid_clear;
    logic        w_enter_discard;
    logic [31:0] w_deliver_instr;
    logic [31:0] w_skid_data;
    logic        w_skid_full;

    assign w_in_req        = (r_state == c_st_req);
    assign w_in_disc       = (r_state == c_st_discard);
    assign w_in_hold       = (r_state == c_st_hold);
    assign w_fetch_hit     = w_in_req & IMemValid & ~PCSrc;
    assign w_take_fetch    = w_fetch_hit & IFIDWrite;
    assign w_to_skid       = w_fetch_hit & ~IFIDWrite;
    assign w_take_skid     = w_in_hold & w_skid_full & IFIDWrite & ~PCSrc;
    assign w_deliver       = w_take_fetch | w_take_skid;
    assign w_deliver_instr = w_take_skid ? w_skid_data : IMemRdata;
    assign w_advance       = w_deliver & PCWrite;
    assign w_skid_clear    = w_in_hold & PCSrc;
    // Redirect with the old response still in flight: keep the bus stable until it lands.
    assign w_enter_discard = w_in_req & PCSrc & ~IMemValid;

    fetch_skid_reg u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_to_skid),
        .i_unload (w_take_skid),
        .i_clear  (w_skid_clear),
        .i_data   (IMemRdata),
        .o_data   (w_skid_data),
        .o_full   (w_skid_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: w_next_state = c_st_req;
            c_st_req: begin
                if (w_to_skid) begin
                    w_next_state = c_st_hold;
                end else if (w_enter_discard) begin
                    w_next_state = c_st_discard;
                end
            end
            c_st_discard: begin
                if (IMemValid) begin
                    w_next_state = c_st_req;
                end
            end
            c_st_hold: begin
                if (PCSrc || IFIDWrite) begin
                    w_next_state = c_st_req;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        IMemReq  = w_in_req | w_in_disc;
        IMemAddr = w_in_disc ? r_disc_addr : r_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_disc_addr <= RESET_PC;
        end else begin
            if (PCSrc) begin
                r_pc <= word_align(BranchTarget);
            end else if (w_advance) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_enter_discard) begin
                r_disc_addr <= r_pc;
            end
        end
    end

    // Any IF/ID write cycle without a delivered instruction becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst || IFIDFlush) begin
            r_ifid_instr <= c_rv_nop;
            r_ifid_pc    <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else if (IFIDWrite) begin
            if (w_deliver) begin
                r_ifid_instr <= w_deliver_instr;
                r_ifid_pc    <= r_pc;
                r_ifid_valid <= 1'b1;
            end else begin
                r_ifid_instr <= c_rv_nop;
                r_ifid_pc    <= 32'd0;
                r_ifid_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!IFIDWrite && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (PCSrc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign IFIDInstr   = r_ifid_instr;
    assign IFIDPC      = r_ifid_pc;
    assign IFIDValid   = r_ifid_valid;
    assign StallCycles = r_stall_cnt;
    assign FlushCount  = r_flush_cnt;

endmodule

`default_nettype wire
